// File: rtl/ct_ifu_addrgen_mc.sv
// ct_ifu_addrgen_mc: multi-channel direct-branch target check for the IFU IB stage.
// Recomputes base + sext(offset) for each branch channel, flags the oldest channel whose
// predicted target is wrong, and issues a pipeline redirect, an L0 BTB fix-up and a
// main-BTB update. Main-BTB updates are buffered in a small fall-through FIFO so that
// back-pressure from the BTB write port never delays the redirect.
// Ports:
//   forever_cpuclk / cpurst        : clock, asynchronous active-high reset
//   ibdp_addrgen_*                 : per-channel branch info (valid, base, offset, predicted
//                                    target, BTB lookup PC, L0 hit and one-hot L0 entry)
//   lbuf_addrgen_*                 : loop-buffer gating of branch checks
//   pcgen_addrgen_cancel           : flush, blocks the next redirect
//   btb_addrgen_upd_ready          : BTB write port accepts the queue head
//   addrgen_pcgen_* / addrgen_xx_pcload / addrgen_ibctrl_cancel / addrgen_mispred_ch : redirect
//   addrgen_btb_*                  : BTB update queue head
//   addrgen_l0_btb_*               : L0 BTB fix-up
//   ifu_hpcp_btb_*                 : performance events
module ct_ifu_addrgen_mc #(
    parameter int unsigned PC_WIDTH     = 64,
    parameter int unsigned OFFSET_WIDTH = 28,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned BTB_IDX_W    = 10,
    parameter int unsigned BTB_TAG_W    = 10,
    parameter int unsigned TGT_W        = 20,
    parameter int unsigned L0_ENTRIES   = 16,
    parameter int unsigned UPDQ_DEPTH   = 4
) (
    input  logic                                   forever_cpuclk,
    input  logic                                   cpurst,
    input  logic [NUM_CH-1:0]                      ibdp_addrgen_branch_valid,
    input  logic [NUM_CH*(PC_WIDTH-1)-1:0]         ibdp_addrgen_branch_base,
    input  logic [NUM_CH*OFFSET_WIDTH-1:0]         ibdp_addrgen_branch_offset,
    input  logic [NUM_CH*(PC_WIDTH-1)-1:0]         ibdp_addrgen_branch_result,
    input  logic [NUM_CH*(PC_WIDTH-1)-1:0]         ibdp_addrgen_btb_index_pc,
    input  logic [NUM_CH-1:0]                      ibdp_addrgen_l0_btb_hit,
    input  logic [NUM_CH*L0_ENTRIES-1:0]           ibdp_addrgen_l0_btb_hit_entry,
    input  logic                                   lbuf_addrgen_active_state,
    input  logic                                   lbuf_addrgen_cache_state,
    input  logic                                   lbuf_addrgen_chgflw_mask,
    input  logic                                   pcgen_addrgen_cancel,
    input  logic                                   btb_addrgen_upd_ready,
    output logic                                   addrgen_pcgen_pcload,
    output logic                                   addrgen_xx_pcload,
    output logic                                   addrgen_ibctrl_cancel,
    output logic [PC_WIDTH-2:0]                    addrgen_pcgen_pc,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] addrgen_mispred_ch,
    output logic                                   addrgen_btb_update_vld,
    output logic [BTB_IDX_W-1:0]                   addrgen_btb_index,
    output logic [BTB_TAG_W-1:0]                   addrgen_btb_tag,
    output logic [TGT_W-1:0]                       addrgen_btb_target_pc,
    output logic                                   addrgen_l0_btb_update_vld,
    output logic [3:0]                             addrgen_l0_btb_wen,
    output logic                                   addrgen_l0_btb_update_vld_bit,
    output logic [L0_ENTRIES-1:0]                  addrgen_l0_btb_update_entry,
    output logic [$clog2(NUM_CH+1)-1:0]            ifu_hpcp_btb_inst_cnt,
    output logic                                   ifu_hpcp_btb_mispred,
    output logic                                   ifu_hpcp_btb_upd_drop
);

    localparam int unsigned PCW   = PC_WIDTH - 1;
    localparam int unsigned OFF_W = OFFSET_WIDTH - 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_CH + 1);
    localparam int unsigned PTR_W = $clog2(UPDQ_DEPTH);
    localparam int unsigned OCC_W = $clog2(UPDQ_DEPTH + 1);

    typedef struct packed {
        logic [BTB_IDX_W-1:0] idx;
        logic [BTB_TAG_W-1:0] tag;
        logic [TGT_W-1:0]     tgt;
    } upd_t;

    // Stage 0: per-channel target recompute and BTB index/tag extraction
    logic                              gate;
    logic [NUM_CH-1:0]                 s0_vld;
    logic [NUM_CH-1:0]                 s0_mis;
    logic [NUM_CH-1:0][PCW-1:0]        s0_cal;
    logic [NUM_CH-1:0][BTB_IDX_W-1:0]  s0_idx;
    logic [NUM_CH-1:0][BTB_TAG_W-1:0]  s0_tag;

    assign gate = ~(lbuf_addrgen_active_state | lbuf_addrgen_cache_state | lbuf_addrgen_chgflw_mask);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [OFF_W-1:0] off;
        logic [PCW-1:0]   ipc;
        assign off       = ibdp_addrgen_branch_offset[c*OFFSET_WIDTH+1 +: OFF_W];
        assign ipc       = ibdp_addrgen_btb_index_pc[c*PCW +: PCW];
        assign s0_vld[c] = ibdp_addrgen_branch_valid[c] & gate;
        // Sized cast of a signed operand sign-extends; the add wraps at PCW bits.
        assign s0_cal[c] = ibdp_addrgen_branch_base[c*PCW +: PCW] + PCW'($signed(off));
        assign s0_mis[c] = (s0_cal[c] != ibdp_addrgen_branch_result[c*PCW +: PCW]);
        assign s0_idx[c] = ipc[BTB_IDX_W+2:3];
        assign s0_tag[c] = {ipc[BTB_IDX_W+BTB_TAG_W-1:BTB_IDX_W+3], ipc[2:0]};
    end

    // Upper index-PC bits and offset bit 0 carry no information for this block
    logic unused_ok;
    assign unused_ok = ^{ibdp_addrgen_branch_offset, ibdp_addrgen_btb_index_pc};

    // Stage 1 register: fields load only on a real, uncancelled capture
    logic                               s1_vld;
    logic [NUM_CH-1:0]                  s1_chvld;
    logic [NUM_CH-1:0]                  s1_mis;
    logic [NUM_CH-1:0][PCW-1:0]         s1_cal;
    logic [NUM_CH-1:0][BTB_IDX_W-1:0]   s1_idx;
    logic [NUM_CH-1:0][BTB_TAG_W-1:0]   s1_tag;
    logic [NUM_CH-1:0]                  s1_l0hit;
    logic [NUM_CH-1:0][L0_ENTRIES-1:0]  s1_l0ent;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            s1_vld   <= 1'b0;
            s1_chvld <= '0;
            s1_mis   <= '0;
            s1_cal   <= '0;
            s1_idx   <= '0;
            s1_tag   <= '0;
            s1_l0hit <= '0;
            s1_l0ent <= '0;
        end else begin
            s1_vld <= (|s0_vld) & ~pcgen_addrgen_cancel;
            if ((|s0_vld) && !pcgen_addrgen_cancel) begin
                s1_chvld <= s0_vld;
                s1_mis   <= s0_mis;
                s1_cal   <= s0_cal;
                s1_idx   <= s0_idx;
                s1_tag   <= s0_tag;
                s1_l0hit <= ibdp_addrgen_l0_btb_hit;
                s1_l0ent <= ibdp_addrgen_l0_btb_hit_entry;
            end
        end
    end

    // Oldest mispredicting channel; count stops at it so younger channels are squashed
    logic [CH_W-1:0]  sel;
    logic             any_mis;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        sel     = '0;
        any_mis = 1'b0;
        cnt     = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!any_mis) begin
                if (s1_chvld[c]) cnt = cnt + CNT_W'(1);
                if (s1_chvld[c] && s1_mis[c]) begin
                    any_mis = 1'b1;
                    sel     = CH_W'(c);
                end
            end
        end
    end

    logic pcload;
    logic l0_upd;

    assign pcload                        = s1_vld & any_mis;
    assign l0_upd                        = pcload & s1_l0hit[sel];
    assign addrgen_pcgen_pcload          = pcload;
    assign addrgen_xx_pcload             = pcload;
    assign addrgen_ibctrl_cancel         = pcload;
    assign addrgen_pcgen_pc              = s1_cal[sel];
    assign addrgen_mispred_ch            = pcload ? sel : '0;
    assign addrgen_l0_btb_update_vld     = l0_upd;
    assign addrgen_l0_btb_wen            = {l0_upd, 3'b000};
    assign addrgen_l0_btb_update_vld_bit = 1'b0;
    assign addrgen_l0_btb_update_entry   = l0_upd ? s1_l0ent[sel] : '0;
    assign ifu_hpcp_btb_inst_cnt         = s1_vld ? cnt : '0;
    assign ifu_hpcp_btb_mispred          = pcload;

    // BTB update FIFO; an empty queue passes the pushed entry straight to the head
    upd_t             mem [UPDQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    upd_t             push_data;
    upd_t             head;
    logic             empty;
    logic             full;
    logic             head_vld;
    logic             pop;
    logic             wr;
    logic             rd_adv;

    assign push_data = {s1_idx[sel], s1_tag[sel], s1_cal[sel][TGT_W-1:0]};
    assign empty     = (occ == '0);
    assign full      = (occ == OCC_W'(UPDQ_DEPTH));
    assign head_vld  = ~empty | pcload;
    assign head      = empty ? push_data : mem[rd_ptr];
    assign pop       = head_vld & btb_addrgen_upd_ready;
    // A bypassed entry (empty queue, consumed this cycle) is never stored
    assign wr        = pcload & ~(empty & pop) & (~full | pop);
    assign rd_adv    = pop & ~empty;

    assign addrgen_btb_update_vld = head_vld;
    assign addrgen_btb_index      = head.idx;
    assign addrgen_btb_tag        = head.tag;
    assign addrgen_btb_target_pc  = head.tgt;
    assign ifu_hpcp_btb_upd_drop  = pcload & full & ~pop;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr)     wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(wr) - OCC_W'(rd_adv);
        end
    end

    // Storage needs no reset: the occupancy count guards every read
    always_ff @(posedge forever_cpuclk) begin
        if (wr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_ct_ifu_addrgen_mc.sv
// Self-checking bench for ct_ifu_addrgen_mc: directed scenarios plus randomized traffic
// checked against a reference model (target arithmetic and a queue of pending updates).
module tb_ct_ifu_addrgen_mc;

    localparam int unsigned PCW  = 63;
    localparam int unsigned OW   = 28;
    localparam int unsigned NCH  = 2;
    localparam int unsigned IDXW = 10;
    localparam int unsigned TAGW = 10;
    localparam int unsigned TGTW = 20;
    localparam int unsigned L0E  = 16;
    localparam int unsigned QD   = 4;
    localparam int unsigned UW   = IDXW + TAGW + TGTW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [PCW-1:0] base_a [NCH];
    logic [PCW-1:0] res_a  [NCH];
    logic [PCW-1:0] ipc_a  [NCH];
    logic [OW-1:0]  off_a  [NCH];
    logic [L0E-1:0] ent_a  [NCH];
    logic [NCH-1:0] bvld, l0hit;
    logic active, cache, mask, cancel, ready;

    logic [NCH*PCW-1:0] base_p, res_p, ipc_p;
    logic [NCH*OW-1:0]  off_p;
    logic [NCH*L0E-1:0] ent_p;

    always_comb begin
        base_p = '0; res_p = '0; ipc_p = '0; off_p = '0; ent_p = '0;
        for (int c = 0; c < NCH; c++) begin
            base_p[c*PCW +: PCW] = base_a[c];
            res_p[c*PCW +: PCW]  = res_a[c];
            ipc_p[c*PCW +: PCW]  = ipc_a[c];
            off_p[c*OW +: OW]    = off_a[c];
            ent_p[c*L0E +: L0E]  = ent_a[c];
        end
    end

    logic            pcload, xx_pcload, ib_cancel, upd_vld, l0_vld, l0_vbit, hpcp_mis, drop;
    logic [PCW-1:0]  pc;
    logic [0:0]      mis_ch;
    logic [IDXW-1:0] btb_idx;
    logic [TAGW-1:0] btb_tag;
    logic [TGTW-1:0] btb_tgt;
    logic [3:0]      l0_wen;
    logic [L0E-1:0]  l0_ent;
    logic [1:0]      inst_cnt;

    ct_ifu_addrgen_mc dut (
        .forever_cpuclk                (clk),
        .cpurst                        (rst),
        .ibdp_addrgen_branch_valid     (bvld),
        .ibdp_addrgen_branch_base      (base_p),
        .ibdp_addrgen_branch_offset    (off_p),
        .ibdp_addrgen_branch_result    (res_p),
        .ibdp_addrgen_btb_index_pc     (ipc_p),
        .ibdp_addrgen_l0_btb_hit       (l0hit),
        .ibdp_addrgen_l0_btb_hit_entry (ent_p),
        .lbuf_addrgen_active_state     (active),
        .lbuf_addrgen_cache_state      (cache),
        .lbuf_addrgen_chgflw_mask      (mask),
        .pcgen_addrgen_cancel          (cancel),
        .btb_addrgen_upd_ready         (ready),
        .addrgen_pcgen_pcload          (pcload),
        .addrgen_xx_pcload             (xx_pcload),
        .addrgen_ibctrl_cancel         (ib_cancel),
        .addrgen_pcgen_pc              (pc),
        .addrgen_mispred_ch            (mis_ch),
        .addrgen_btb_update_vld        (upd_vld),
        .addrgen_btb_index             (btb_idx),
        .addrgen_btb_tag               (btb_tag),
        .addrgen_btb_target_pc         (btb_tgt),
        .addrgen_l0_btb_update_vld     (l0_vld),
        .addrgen_l0_btb_wen            (l0_wen),
        .addrgen_l0_btb_update_vld_bit (l0_vbit),
        .addrgen_l0_btb_update_entry   (l0_ent),
        .ifu_hpcp_btb_inst_cnt         (inst_cnt),
        .ifu_hpcp_btb_mispred          (hpcp_mis),
        .ifu_hpcp_btb_upd_drop         (drop)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: what the outputs should show in the current cycle
    logic           e_pcload;
    logic [PCW-1:0] e_pc;
    logic [0:0]     e_ch;
    logic [1:0]     e_cnt;
    logic           e_l0vld;
    logic [L0E-1:0] e_l0ent;
    logic [UW-1:0]  e_push;
    logic [UW-1:0]  mq [$];

    function automatic logic [PCW-1:0] calc_cal(input logic [PCW-1:0] b, input logic [OW-1:0] o);
        longint d;
        logic [63:0] s;
        d = longint'(o >> 1);
        if (o[OW-1]) d = d - (longint'(1) << (OW - 1));
        s = {1'b0, b} + 64'(d);
        return s[PCW-1:0];
    endfunction

    function automatic logic [UW-1:0] upd_entry(input logic [PCW-1:0] ipc, input logic [PCW-1:0] cal);
        longint unsigned v, idx, tag;
        v   = 64'(ipc);
        idx = (v >> 3) % 1024;
        tag = ((v >> 13) % 128) * 8 + v % 8;
        return {IDXW'(idx), TAGW'(tag), cal[TGTW-1:0]};
    endfunction

    function automatic logic exp_hvld();
        return (mq.size() > 0) || e_pcload;
    endfunction

    function automatic logic [UW-1:0] exp_head();
        return (mq.size() > 0) ? mq[0] : e_push;
    endfunction

    function automatic logic exp_drop();
        return e_pcload && (mq.size() == QD) && !ready;
    endfunction

    task automatic model_reset();
        mq.delete();
        e_pcload = 1'b0; e_cnt = '0; e_l0vld = 1'b0; e_ch = '0;
        e_pc = '0; e_l0ent = '0; e_push = '0;
    endtask

    task automatic model_queue();
        int sz;
        sz = mq.size();
        if (e_pcload) begin
            if (sz == 0) begin
                if (!ready) mq.push_back(e_push);
            end else begin
                if (ready) void'(mq.pop_front());
                if (sz < QD || ready) mq.push_back(e_push);
            end
        end else if (ready && sz > 0) begin
            void'(mq.pop_front());
        end
    endtask

    task automatic model_capture();
        logic [PCW-1:0] cal;
        e_pcload = 1'b0; e_cnt = '0; e_l0vld = 1'b0;
        if (cancel || active || cache || mask || bvld == '0) return;
        for (int c = 0; c < NCH; c++) begin
            if (bvld[c]) begin
                e_cnt = e_cnt + 2'd1;
                cal = calc_cal(base_a[c], off_a[c]);
                if (cal != res_a[c]) begin
                    e_pcload = 1'b1; e_pc = cal; e_ch = 1'(c);
                    e_l0vld = l0hit[c]; e_l0ent = ent_a[c];
                    e_push = upd_entry(ipc_a[c], cal);
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        model_queue();
        model_capture();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < NCH; c++) begin
            base_a[c] = '0; res_a[c] = '0; ipc_a[c] = '0; off_a[c] = '0; ent_a[c] = '0;
        end
        bvld = '0; l0hit = '0; active = 0; cache = 0; mask = 0; cancel = 0; ready = 0;
    endtask

    task automatic set_ch(input int c, input logic [PCW-1:0] b, input logic [OW-1:0] o,
                          input logic [PCW-1:0] r, input logic [PCW-1:0] ipc);
        base_a[c] = b; off_a[c] = o; res_a[c] = r; ipc_a[c] = ipc;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_chk++; if ({pcload, xx_pcload, ib_cancel, hpcp_mis} !== 4'b0) $display("FAIL reset_pcload got=%0h exp=0", {pcload, xx_pcload, ib_cancel, hpcp_mis}); else n_pass++;
        n_chk++; if ({upd_vld, btb_idx, btb_tag, btb_tgt} !== '0) $display("FAIL reset_btb got=%0h exp=0", {upd_vld, btb_idx, btb_tag, btb_tgt}); else n_pass++;
        n_chk++; if ({l0_vld, l0_wen, l0_vbit, l0_ent} !== '0) $display("FAIL reset_l0 got=%0h exp=0", {l0_vld, l0_wen, l0_vbit, l0_ent}); else n_pass++;
        n_chk++; if ({pc, mis_ch, inst_cnt, drop} !== '0) $display("FAIL reset_misc got=%0h exp=0", {pc, mis_ch, inst_cnt, drop}); else n_pass++;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        clear_inputs();
        ready = 1'b1;
        set_ch(0, 63'h1000, 28'h40, 63'h1020, 63'h1000);
        set_ch(1, 63'h2000, 28'h100, 63'h3000, 63'h2080);
        bvld = 2'b11;
        #1; tick();
        bvld = '0;
        #1;
        n_chk++; if ({pcload, xx_pcload, ib_cancel, hpcp_mis} !== 4'hF) $display("FAIL basic_pcload got=%0h exp=f", {pcload, xx_pcload, ib_cancel, hpcp_mis}); else n_pass++;
        n_chk++; if (pc !== 63'h2080) $display("FAIL basic_pc got=%0h exp=2080", pc); else n_pass++;
        n_chk++; if (mis_ch !== 1'b1) $display("FAIL basic_ch got=%0h exp=1", mis_ch); else n_pass++;
        n_chk++; if (inst_cnt !== 2'd2) $display("FAIL basic_cnt got=%0d exp=2", inst_cnt); else n_pass++;
        n_chk++; if ({upd_vld, btb_idx, btb_tag, btb_tgt} !== {1'b1, 10'h010, 10'h008, 20'h02080}) $display("FAIL basic_btb got=%0h exp=%0h", {upd_vld, btb_idx, btb_tag, btb_tgt}, {1'b1, 10'h010, 10'h008, 20'h02080}); else n_pass++;
        n_chk++; if ({l0_vld, l0_wen, drop} !== '0) $display("FAIL basic_l0 got=%0h exp=0", {l0_vld, l0_wen, drop}); else n_pass++;
        tick();
        n_chk++; if ({pcload, upd_vld, inst_cnt} !== '0) $display("FAIL basic_pulse got=%0h exp=0", {pcload, upd_vld, inst_cnt}); else n_pass++;
    endtask

    task automatic test_both_mis();
        clear_inputs();
        set_ch(0, 63'h1000, 28'h40, 63'h0, 63'h1000);
        set_ch(1, 63'h2000, 28'h100, 63'h3000, 63'h2080);
        l0hit = 2'b01; ent_a[0] = 16'h0004; ent_a[1] = 16'h0100;
        bvld = 2'b11;
        #1; tick();
        bvld = '0;
        #1;
        n_chk++; if ({pc, mis_ch, inst_cnt} !== {63'h1020, 1'b0, 2'd1}) $display("FAIL both_sel got=%0h exp=%0h", {pc, mis_ch, inst_cnt}, {63'h1020, 1'b0, 2'd1}); else n_pass++;
        n_chk++; if ({l0_vld, l0_wen, l0_vbit, l0_ent} !== {1'b1, 4'b1000, 1'b0, 16'h0004}) $display("FAIL both_l0 got=%0h exp=%0h", {l0_vld, l0_wen, l0_vbit, l0_ent}, {1'b1, 4'b1000, 1'b0, 16'h0004}); else n_pass++;
        n_chk++; if ({upd_vld, btb_idx, btb_tag, btb_tgt} !== {1'b1, 10'h200, 10'h000, 20'h01020}) $display("FAIL both_btb got=%0h exp=%0h", {upd_vld, btb_idx, btb_tag, btb_tgt}, {1'b1, 10'h200, 10'h000, 20'h01020}); else n_pass++;
        tick();
        n_chk++; if ({pcload, l0_vld, upd_vld, btb_tgt} !== {1'b0, 1'b0, 1'b1, 20'h01020}) $display("FAIL both_held got=%0h exp=%0h", {pcload, l0_vld, upd_vld, btb_tgt}, {1'b0, 1'b0, 1'b1, 20'h01020}); else n_pass++;
        ready = 1'b1;
        #1; tick();
        n_chk++; if (upd_vld !== 1'b0) $display("FAIL both_one_entry got=%0h exp=0", upd_vld); else n_pass++;
    endtask

    task automatic test_neg_offset();
        clear_inputs();
        ready = 1'b1;
        set_ch(0, 63'h0, 28'h8000000, 63'h0, 63'h0);
        bvld = 2'b01;
        #1; tick();
        set_ch(0, 63'h1000, 28'h40, 63'h1020, 63'h0);
        set_ch(1, 63'h7FFF_FFFF_FFFF_FFF0, 28'h40, 63'h0, 63'h0);
        bvld = 2'b11;
        #1;
        n_chk++; if ({pcload, pc} !== {1'b1, 63'h7FFF_FFFF_FC00_0000}) $display("FAIL neg_wrap got=%0h exp=%0h", {pcload, pc}, {1'b1, 63'h7FFF_FFFF_FC00_0000}); else n_pass++;
        tick();
        bvld = '0;
        #1;
        n_chk++; if ({pcload, pc, mis_ch, inst_cnt} !== {1'b1, 63'h10, 1'b1, 2'd2}) $display("FAIL pos_wrap got=%0h exp=%0h", {pcload, pc, mis_ch, inst_cnt}, {1'b1, 63'h10, 1'b1, 2'd2}); else n_pass++;
        tick();
    endtask

    task automatic test_queue_full();
        logic [TGTW-1:0] order [4];
        order[0] = 20'h04120; order[1] = 20'h04220; order[2] = 20'h04320; order[3] = 20'h04520;
        clear_inputs();
        for (int k = 0; k <= 6; k++) begin
            if (k <= 5) begin
                set_ch(0, 63'(64'h4000 + 64'(k) * 64'h100), 28'h40, 63'h0, 63'h0);
                bvld = 2'b01;
            end else begin
                bvld = '0;
            end
            ready = (k == 6);
            #1;
            if (k >= 1) begin
                n_chk++; if ({pcload, drop} !== {1'b1, (k == 5)}) $display("FAIL qfull_drop_k%0d got=%0h exp=%0h", k, {pcload, drop}, {1'b1, (k == 5)}); else n_pass++;
                n_chk++; if ({upd_vld, btb_tgt} !== {1'b1, 20'h04020}) $display("FAIL qfull_head_k%0d got=%0h exp=%0h", k, {upd_vld, btb_tgt}, {1'b1, 20'h04020}); else n_pass++;
            end
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            #1;
            n_chk++; if ({upd_vld, btb_tgt} !== {1'b1, order[j]}) $display("FAIL qdrain_%0d got=%0h exp=%0h", j, {upd_vld, btb_tgt}, {1'b1, order[j]}); else n_pass++;
            tick();
        end
        n_chk++; if (upd_vld !== 1'b0) $display("FAIL qdrain_empty got=%0h exp=0", upd_vld); else n_pass++;
    endtask

    task automatic test_cancel_mask();
        clear_inputs();
        set_ch(0, 63'h5000, 28'h40, 63'h0, 63'h0);
        bvld = 2'b01;
        #1; tick();
        bvld = '0;
        #1; tick();
        set_ch(0, 63'h6000, 28'h40, 63'h0, 63'h0);
        bvld = 2'b01; cancel = 1'b1;
        #1; tick();
        bvld = '0; cancel = 1'b0;
        #1;
        n_chk++; if ({pcload, inst_cnt, hpcp_mis, drop} !== '0) $display("FAIL cancel_nopcload got=%0h exp=0", {pcload, inst_cnt, hpcp_mis, drop}); else n_pass++;
        n_chk++; if ({upd_vld, btb_tgt} !== {1'b1, 20'h05020}) $display("FAIL cancel_queue got=%0h exp=%0h", {upd_vld, btb_tgt}, {1'b1, 20'h05020}); else n_pass++;
        set_ch(0, 63'h7000, 28'h40, 63'h0, 63'h0);
        bvld = 2'b01;
        #1; tick();
        bvld = '0; cancel = 1'b1;
        #1;
        n_chk++; if ({pcload, pc} !== {1'b1, 63'h7020}) $display("FAIL cancel_late got=%0h exp=%0h", {pcload, pc}, {1'b1, 63'h7020}); else n_pass++;
        tick();
        cancel = 1'b0;
        #1;
        n_chk++; if (pcload !== 1'b0) $display("FAIL cancel_after got=%0h exp=0", pcload); else n_pass++;
        for (int g = 0; g < 3; g++) begin
            active = (g == 0); cache = (g == 1); mask = (g == 2);
            set_ch(1, 63'h9000, 28'h40, 63'h0, 63'h0);
            bvld = 2'b11;
            #1; tick();
            active = 0; cache = 0; mask = 0; bvld = '0;
            #1;
            n_chk++; if ({pcload, inst_cnt} !== '0) $display("FAIL gate_%0d got=%0h exp=0", g, {pcload, inst_cnt}); else n_pass++;
        end
        ready = 1'b1;
        repeat (QD) begin #1; tick(); end
        #1;
        n_chk++; if ({upd_vld, btb_tgt} !== {1'b0, 20'h07020}) $display("FAIL cancel_drain got=%0h exp=%0h", {upd_vld, btb_tgt}, {1'b0, 20'h07020}); else n_pass++;
    endtask

    task automatic test_random();
        logic [UW-1:0] eh;
        clear_inputs();
        for (int it = 0; it < 400; it++) begin
            for (int c = 0; c < NCH; c++) begin
                base_a[c] = 63'({$urandom, $urandom});
                off_a[c]  = 28'($urandom);
                ipc_a[c]  = 63'({$urandom, $urandom});
                ent_a[c]  = 16'(1) << $urandom_range(15);
                res_a[c]  = ($urandom_range(1) == 1) ? calc_cal(base_a[c], off_a[c]) : 63'({$urandom, $urandom});
            end
            bvld   = 2'($urandom);
            l0hit  = 2'($urandom);
            active = ($urandom_range(15) == 0);
            cache  = ($urandom_range(15) == 0);
            mask   = ($urandom_range(15) == 0);
            cancel = ($urandom_range(7) == 0);
            ready  = ($urandom_range(9) < 4);
            #1;
            n_chk++; if ({pcload, hpcp_mis, inst_cnt} !== {e_pcload, e_pcload, e_cnt}) $display("FAIL rnd_pcload_%0d got=%0h exp=%0h", it, {pcload, hpcp_mis, inst_cnt}, {e_pcload, e_pcload, e_cnt}); else n_pass++;
            if (e_pcload) begin
                n_chk++; if ({pc, mis_ch} !== {e_pc, e_ch}) $display("FAIL rnd_pc_%0d got=%0h exp=%0h", it, {pc, mis_ch}, {e_pc, e_ch}); else n_pass++;
                n_chk++; if ({l0_vld, l0_wen} !== {e_l0vld, e_l0vld, 3'b000}) $display("FAIL rnd_l0_%0d got=%0h exp=%0h", it, {l0_vld, l0_wen}, {e_l0vld, e_l0vld, 3'b000}); else n_pass++;
                if (e_l0vld) begin
                    n_chk++; if (l0_ent !== e_l0ent) $display("FAIL rnd_l0ent_%0d got=%0h exp=%0h", it, l0_ent, e_l0ent); else n_pass++;
                end
            end
            n_chk++; if ({upd_vld, drop} !== {exp_hvld(), exp_drop()}) $display("FAIL rnd_q_%0d got=%0h exp=%0h", it, {upd_vld, drop}, {exp_hvld(), exp_drop()}); else n_pass++;
            if (exp_hvld()) begin
                eh = exp_head();
                n_chk++; if ({btb_idx, btb_tag, btb_tgt} !== eh) $display("FAIL rnd_head_%0d got=%0h exp=%0h", it, {btb_idx, btb_tag, btb_tgt}, eh); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            set_ch(0, 63'(64'h8000 + 64'(k) * 64'h100), 28'h40, 63'h0, 63'h8000);
            bvld = 2'b01;
            #1; tick();
        end
        bvld = '0; ready = 1'b1;
        #1;
        n_chk++; if ({pcload, upd_vld} !== 2'b11) $display("FAIL rstmid_pre got=%0h exp=3", {pcload, upd_vld}); else n_pass++;
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        n_chk++; if ({pcload, upd_vld, inst_cnt, hpcp_mis, drop, l0_vld} !== '0) $display("FAIL rstmid_ctl got=%0h exp=0", {pcload, upd_vld, inst_cnt, hpcp_mis, drop, l0_vld}); else n_pass++;
        n_chk++; if ({pc, btb_idx, btb_tag, btb_tgt} !== '0) $display("FAIL rstmid_data got=%0h exp=0", {pc, btb_idx, btb_tag, btb_tgt}); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b0;
        #1;
        n_chk++; if (upd_vld !== 1'b0) $display("FAIL rstmid_empty got=%0h exp=0", upd_vld); else n_pass++;
        tick();
        n_chk++; if ({pcload, upd_vld} !== 2'b00) $display("FAIL rstmid_after got=%0h exp=0", {pcload, upd_vld}); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_both_mis();
        test_neg_offset();
        test_queue_full();
        test_cancel_mask();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ct_ifu_addrgen_mc.md
# ct_ifu_addrgen_mc

Multi-channel branch address generator for the IFU IB stage. Up to NUM_CH direct branches per fetch packet have their targets recomputed as base + sign-extended offset and checked against the BTB-predicted target. The oldest mispredicting channel is registered and drives a pipeline redirect and an L0 BTB fix-up. Main-BTB updates go through a small valid/ready queue, so back-pressure from the BTB write port never stalls the redirect.

## Interface
Parameters:
- PC_WIDTH, 64: architectural PC width; internal PCs are PC_WIDTH-1 bits (halfword units).
- OFFSET_WIDTH, 28: branch offset width; bit 0 is dropped.
- NUM_CH, 2: branch channels per cycle; channel 0 is oldest in program order.
- BTB_IDX_W, 10 / BTB_TAG_W, 10 / TGT_W, 20: BTB index, tag and stored-target widths.
- L0_ENTRIES, 16: L0 BTB entries; sets the one-hot width.
- UPDQ_DEPTH, 4: BTB update queue depth; power of two, ≥2.

Ports:
- Clock and reset: already decided — one clock; reset is asynchronous and active-high.
  - forever_cpuclk, in, 1: clock.
  - cpurst, in, 1: asynchronous, active-high reset.
- ibdp_addrgen_branch_valid, in, NUM_CH: per-channel branch present.
- ibdp_addrgen_branch_base, in, NUM_CH*(PC_WIDTH-1): per-channel base PC.
- ibdp_addrgen_branch_offset, in, NUM_CH*OFFSET_WIDTH: per-channel raw offset.
- ibdp_addrgen_branch_result, in, NUM_CH*(PC_WIDTH-1): predicted target.
- ibdp_addrgen_btb_index_pc, in, NUM_CH*(PC_WIDTH-1): BTB lookup PC.
- ibdp_addrgen_l0_btb_hit, in, NUM_CH: L0 hit per channel.
- ibdp_addrgen_l0_btb_hit_entry, in, NUM_CH*L0_ENTRIES: one-hot L0 entry.
- lbuf_addrgen_active_state, lbuf_addrgen_cache_state, lbuf_addrgen_chgflw_mask, in, 1 each: loop-buffer gating.
- pcgen_addrgen_cancel, in, 1: flush.
- btb_addrgen_upd_ready, in, 1: BTB write port accepts.
- addrgen_pcgen_pcload, addrgen_xx_pcload, addrgen_ibctrl_cancel, out, 1: redirect.
- addrgen_pcgen_pc, out, PC_WIDTH-1: redirect target.
- addrgen_mispred_ch, out, clog2(NUM_CH) (min 1): selected channel.
- addrgen_btb_update_vld, out, 1: queue head valid.
- addrgen_btb_index, out, BTB_IDX_W / addrgen_btb_tag, out, BTB_TAG_W / addrgen_btb_target_pc, out, TGT_W: queue head fields.
- addrgen_l0_btb_update_vld, out, 1 / addrgen_l0_btb_wen, out, 4 / addrgen_l0_btb_update_vld_bit, out, 1 / addrgen_l0_btb_update_entry, out, L0_ENTRIES: L0 fix-up.
- ifu_hpcp_btb_inst_cnt, out, clog2(NUM_CH+1): branches checked.
- ifu_hpcp_btb_mispred, out, 1: mispredict event.
- ifu_hpcp_btb_upd_drop, out, 1: update lost because the queue was full.

## Operation
Stage 0 (combinational), per channel c:
- vld_c = valid[c] & !active_state & !cache_state & !chgflw_mask.
- cal_c = base_c + sext(offset_c[OFFSET_WIDTH-1:1]), computed modulo 2^(PC_WIDTH-1).
- mis_c = (cal_c != result_c).
- idx_c = index_pc_c[BTB_IDX_W+2:3].
- tag_c = {index_pc_c[BTB_IDX_W+BTB_TAG_W-1 : BTB_IDX_W+3], index_pc_c[2:0]}.

Stage 1 register:
- Captured only when any vld_c is set; otherwise holds.
- Fields held: per-channel vld/mis/cal/idx/tag/l0 hit/entry.
- Stage valid s1_vld <= |vld & !pcgen_addrgen_cancel.
- Cancel takes priority over new capture.

Selection at stage 1:
- sel = lowest c with vld_c & mis_c.
- any_mis = sel exists.
- pcload = s1_vld & any_mis; addrgen_pcgen_pc = cal_sel.
- addrgen_mispred_ch = sel, or 0 when there is no mispredict.
- Channels younger than sel are squashed: not counted, not updated.
- ifu_hpcp_btb_inst_cnt = number of valid channels ≤ sel (all valid channels when there is no mispredict), gated by s1_vld.
- ifu_hpcp_btb_mispred = pcload.

L0 fix-up, same cycle as pcload:
- update_vld = pcload & l0_hit_sel.
- wen = {update_vld, 3'b0}; vld_bit = 0; entry = l0_entry_sel.

BTB update queue (FIFO, UPDQ_DEPTH entries of {idx, tag, cal[TGT_W-1:0]}):
- push = pcload; pop = head valid & upd_ready.
- Push into a full queue is accepted only when pop happens the same cycle; otherwise the push is dropped and ifu_hpcp_btb_upd_drop pulses for 1 cycle.
- Cancel does not affect the queue.

## Timing
- Reset: all outputs 0; s1 fields cleared; queue empty (pointers 0, count 0).
- Redirect latency: branch valid in cycle N gives pcload in cycle N+1, a single-cycle pulse per capture.
- Cancel in cycle N: no pcload in N+1. It cannot suppress a pcload already asserted in cycle N.
- BTB update: earliest on addrgen_btb_update_vld in N+1, because the queue is fall-through when empty.
- Queue ordering: FIFO order; head fields are stable while vld & !ready.
- Occupancy count spans 0..UPDQ_DEPTH; pointers wrap modulo UPDQ_DEPTH.
- Reset asserted mid-operation: asynchronous clear of everything within the same cycle.

## Test plan
- NUM_CH=2; ch0 base 0x1000, offset 0x40 (target 0x1020), pred 0x1020; ch1 mispredicts -> N+1: pcload=1, pc=ch1 cal, mispred_ch=1, inst_cnt=2, one queue push.
- Both channels mispredict, ch0 L0 hit entry 0x0004 -> pc=ch0 cal, inst_cnt=1, l0 wen=4'b1000, entry=0x0004, ch1 not queued.
- Negative offset 0x8000000 with base 0x0 -> cal wraps to 0x7FFF_FFFF_FC00_0000 (masked to PC_WIDTH-1 bits).
- Hold upd_ready=0, issue 5 mispredicts -> 4 queued, 5th raises upd_drop; push with ready=1 while full -> accepted, no drop; drain order matches push order.
- Cancel with branch valid in the same cycle -> no pcload in N+1; queue contents unchanged. chgflw_mask=1 -> no capture, inst_cnt=0.
- Assert cpurst mid-drain -> all outputs 0 immediately, queue empty after release.
